register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file_pkg.sv | 11 +
 rtl/register_file.sv | 94 +++++++++
 tb/tb_register_file.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/register_file_pkg.sv
// Shared core dimensions: data width, register/ROB index widths and table sizes.
// The ROB imports this package as well, so both blocks agree on tag and index sizes.
package register_file_pkg;

    localparam int XLEN_DEFAULT      = 32;
    localparam int REG_IDX_W_DEFAULT = 5;
    localparam int ROB_IDX_W_DEFAULT = 4;
    localparam int ROB_SIZE          = 1 << ROB_IDX_W_DEFAULT;
    localparam int NUM_REGS          = 32;

endpackage : register_file_pkg

// File: rtl/register_file.sv
// Architectural register file with rename status: each register holds a value,
// a busy flag and the ROB tag of its pending producer, with a commit bypass on both read ports.
module register_file
    import register_file_pkg::*;
#(
    parameter int ROB_IDX_W = ROB_IDX_W_DEFAULT,
    parameter int REG_IDX_W = REG_IDX_W_DEFAULT,
    parameter int XLEN      = XLEN_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,

    input  logic                 ren_valid,
    input  logic [REG_IDX_W-1:0] ren_rd,
    input  logic [ROB_IDX_W-1:0] ren_rob_id,

    input  logic                 cmt_valid,
    input  logic [REG_IDX_W-1:0] cmt_rd,
    input  logic [ROB_IDX_W-1:0] cmt_rob_id,
    input  logic [XLEN-1:0]      cmt_value,

    input  logic                 roll_back,

    input  logic [REG_IDX_W-1:0] rs1_idx,
    input  logic [REG_IDX_W-1:0] rs2_idx,
    output logic [XLEN-1:0]      rs1_value,
    output logic [XLEN-1:0]      rs2_value,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic [ROB_IDX_W-1:0] rs1_tag,
    output logic [ROB_IDX_W-1:0] rs2_tag
);

    localparam int RD_W = XLEN + 1 + ROB_IDX_W;

    logic [XLEN-1:0]      values [NUM_REGS];
    logic [ROB_IDX_W-1:0] tags   [NUM_REGS];
    logic [NUM_REGS-1:0]  busy;

    logic cmt_en;
    logic ren_en;

    assign cmt_en = cmt_valid && (cmt_rd != '0);
    assign ren_en = ren_valid && (ren_rd != '0) && !roll_back;

    // Rename is applied after commit so a same-cycle rename of the same register keeps it busy
    // under the new tag; a commit only releases the register if it is still the newest producer.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                values[i] <= '0;
                tags[i]   <= '0;
            end
            busy <= '0;
        end else if (rdy) begin
            if (cmt_en) begin
                values[cmt_rd] <= cmt_value;
                if (tags[cmt_rd] == cmt_rob_id) begin
                    busy[cmt_rd] <= 1'b0;
                end
            end
            if (roll_back) begin
                busy <= '0;
            end else if (ren_en) begin
                busy[ren_rd] <= 1'b1;
                tags[ren_rd] <= ren_rob_id;
            end
        end
    end

    // One read port: x0 is hardwired, and a matching commit this cycle is forwarded as already done.
    function automatic logic [RD_W-1:0] read_port(input logic [REG_IDX_W-1:0] idx);
        logic [XLEN-1:0]      val;
        logic                 bsy;
        logic [ROB_IDX_W-1:0] tag;
        val = values[idx];
        bsy = busy[idx];
        tag = tags[idx];
        if (idx == '0) begin
            val = '0;
            bsy = 1'b0;
            tag = '0;
        end else if (rdy && cmt_valid && (cmt_rd == idx) && bsy && (tag == cmt_rob_id)) begin
            val = cmt_value;
            bsy = 1'b0;
        end
        return {val, bsy, tag};
    endfunction

    assign {rs1_value, rs1_busy, rs1_tag} = read_port(rs1_idx);
    assign {rs2_value, rs2_busy, rs2_tag} = read_port(rs2_idx);

endmodule : register_file

// File: tb/tb_register_file.sv
// Table-driven bench for register_file: each step drives one cycle of rename/commit/rollback
// traffic and checks both read ports against hand-derived values through a scoreboard queue.
module tb_register_file;
    import register_file_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        ren_valid;
    logic [4:0]  ren_rd;
    logic [3:0]  ren_rob_id;
    logic        cmt_valid;
    logic [4:0]  cmt_rd;
    logic [3:0]  cmt_rob_id;
    logic [31:0] cmt_value;
    logic        roll_back;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    logic        rs1_busy;
    logic        rs2_busy;
    logic [3:0]  rs1_tag;
    logic [3:0]  rs2_tag;

    always #5 clk = ~clk;

    register_file dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .ren_valid  (ren_valid),
        .ren_rd     (ren_rd),
        .ren_rob_id (ren_rob_id),
        .cmt_valid  (cmt_valid),
        .cmt_rd     (cmt_rd),
        .cmt_rob_id (cmt_rob_id),
        .cmt_value  (cmt_value),
        .roll_back  (roll_back),
        .rs1_idx    (rs1_idx),
        .rs2_idx    (rs2_idx),
        .rs1_value  (rs1_value),
        .rs2_value  (rs2_value),
        .rs1_busy   (rs1_busy),
        .rs2_busy   (rs2_busy),
        .rs1_tag    (rs1_tag),
        .rs2_tag    (rs2_tag)
    );

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        ren_valid;
        logic [4:0]  ren_rd;
        logic [3:0]  ren_tag;
        logic        cmt_valid;
        logic [4:0]  cmt_rd;
        logic [3:0]  cmt_tag;
        logic [31:0] cmt_val;
        logic        roll_back;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] e1_val;
        logic        e1_busy;
        logic [3:0]  e1_tag;
        logic [31:0] e2_val;
        logic        e2_busy;
        logic [3:0]  e2_tag;
        bit          chk_tag;
    } vec_t;

    typedef struct {
        int          step;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] v1;
        logic        b1;
        logic [3:0]  t1;
        logic [31:0] v2;
        logic        b2;
        logic [3:0]  t2;
        bit          chk_tag;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic vec_t mk(bit r, bit en, bit rv, int rrd, int rtag, bit cv, int crd, int ctag,
                                logic [31:0] cval, bit rb, int a1, int a2,
                                logic [31:0] v1, bit b1, int t1, logic [31:0] v2, bit b2, int t2,
                                bit ct);
        vec_t v;
        v.rst = r; v.rdy = en;
        v.ren_valid = rv; v.ren_rd = 5'(rrd); v.ren_tag = 4'(rtag);
        v.cmt_valid = cv; v.cmt_rd = 5'(crd); v.cmt_tag = 4'(ctag); v.cmt_val = cval;
        v.roll_back = rb; v.rs1 = 5'(a1); v.rs2 = 5'(a2);
        v.e1_val = v1; v.e1_busy = b1; v.e1_tag = 4'(t1);
        v.e2_val = v2; v.e2_busy = b2; v.e2_tag = 4'(t2);
        v.chk_tag = ct;
        return v;
    endfunction

    task automatic check_val(string name, int step, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s step %0d: got 0x%08h, expected 0x%08h", name, step, act, exp);
    endtask

    // Tags are only meaningful while busy, for x0, or where reset left them at a known zero.
    task automatic check_output();
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            $display("[TB] FAIL scoreboard_empty: got 0 entries, expected 1");
            return;
        end
        e = sb.pop_front();
        check_val("rs1_value", e.step, rs1_value, e.v1);
        check_val("rs1_busy",  e.step, 32'(rs1_busy), 32'(e.b1));
        if (e.b1 || e.rs1 == 5'd0 || e.chk_tag)
            check_val("rs1_tag", e.step, 32'(rs1_tag), 32'(e.t1));
        check_val("rs2_value", e.step, rs2_value, e.v2);
        check_val("rs2_busy",  e.step, 32'(rs2_busy), 32'(e.b2));
        if (e.b2 || e.rs2 == 5'd0 || e.chk_tag)
            check_val("rs2_tag", e.step, 32'(rs2_tag), 32'(e.t2));
    endtask

    task automatic apply_stimulus(vec_t v, int step);
        exp_t e;
        @(negedge clk);
        rst        = v.rst;
        rdy        = v.rdy;
        ren_valid  = v.ren_valid;
        ren_rd     = v.ren_rd;
        ren_rob_id = v.ren_tag;
        cmt_valid  = v.cmt_valid;
        cmt_rd     = v.cmt_rd;
        cmt_rob_id = v.cmt_tag;
        cmt_value  = v.cmt_val;
        roll_back  = v.roll_back;
        rs1_idx    = v.rs1;
        rs2_idx    = v.rs2;
        e.step = step; e.rs1 = v.rs1; e.rs2 = v.rs2;
        e.v1 = v.e1_val; e.b1 = v.e1_busy; e.t1 = v.e1_tag;
        e.v2 = v.e2_val; e.b2 = v.e2_busy; e.t2 = v.e2_tag;
        e.chk_tag = v.chk_tag;
        sb.push_back(e);
        #2;
        check_output();
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b0; ren_valid = 1'b0; ren_rd = '0; ren_rob_id = '0;
        cmt_valid = 1'b0; cmt_rd = '0; cmt_rob_id = '0; cmt_value = '0; roll_back = 1'b0;
        rs1_idx = '0; rs2_idx = '0;
        repeat (3) @(posedge clk);

        //            rst rdy rv rrd rt  cv crd ct cval          rb rs1 rs2 v1            b1 t1  v2            b2 t2  ct
        vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0, 32'h0,        0, 5, 0,  32'h0,        0, 0,  32'h0,        0, 0,  1));
        vecs.push_back(mk(0, 1, 1, 5, 3,  0, 0, 0, 32'h0,        0, 5, 6,  32'h0,        0, 0,  32'h0,        0, 0,  1));
        vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0, 32'h0,        0, 5, 0,  32'h0,        1, 3,  32'h0,        0, 0,  0));
        vecs.push_back(mk(0, 1, 0, 0, 0,  1, 5, 3, 32'hDEADBEEF, 0, 5, 0,  32'hDEADBEEF, 0, 3,  32'h0,        0, 0,  0));
        vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0, 32'h0,        0, 5, 6,  32'hDEADBEEF, 0, 3,  32'h0,        0, 0,  0));
        vecs.push_back(mk(0, 1, 1, 5, 3,  0, 0, 0, 32'h0,        0, 5, 0,  32'hDEADBEEF, 0, 3,  32'h0,        0, 0,  0));
        vecs.push_back(mk(0, 1, 1, 5, 7,  0, 0, 0, 32'h0,        0, 5, 0,  32'hDEADBEEF, 1, 3,  32'h0,        0, 0,  0));
        vecs.push_back(mk(0, 1, 0, 0, 0,  1, 5, 3, 32'h11,       0, 5, 0,  32'hDEADBEEF, 1, 7,  32'h0,        0, 0,  0));
        vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0, 32'h0,        0, 5, 6,  32'h11,       1, 7,  32'h0,        0, 0,  1));
        vecs.push_back(mk(0, 1, 1, 6, 9,  1, 6, 2, 32'h22,       0, 6, 5,  32'h0,        0, 0,  32'h11,       1, 7,  1));
        vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0, 32'h0,        0, 6, 5,  32'h22,       1, 9,  32'h11,       1, 7,  0));
        vecs.push_back(mk(0, 1, 1, 1, 1,  0, 0, 0, 32'h0,        0, 1, 2,  32'h0,        0, 0,  32'h0,        0, 0,  1));
        vecs.push_back(mk(0, 1, 1, 2, 2,  0, 0, 0, 32'h0,        0, 1, 2,  32'h0,        1, 1,  32'h0,        0, 0,  1));
        vecs.push_back(mk(0, 1, 1, 3, 3,  0, 0, 0, 32'h0,        0, 3, 4,  32'h0,        0, 0,  32'h0,        0, 0,  1));
        vecs.push_back(mk(0, 1, 1, 4, 4,  0, 0, 0, 32'h0,        0, 3, 2,  32'h0,        1, 3,  32'h0,        1, 2,  0));
        vecs.push_back(mk(0, 1, 1, 8, 8,  1, 1, 1, 32'h44,       1, 4, 1,  32'h0,        1, 4,  32'h44,       0, 1,  1));
        vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0, 32'h0,        0, 1, 8,  32'h44,       0, 1,  32'h0,        0, 0,  1));
        vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0, 32'h0,        0, 4, 5,  32'h0,        0, 4,  32'h11,       0, 7,  0));
        vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0, 32'h0,        0, 6, 2,  32'h22,       0, 0,  32'h0,        0, 0,  0));
        vecs.push_back(mk(0, 1, 1, 0, 5,  1, 0, 0, 32'h55,       0, 0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  0));
        vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0, 32'h0,        0, 0, 3,  32'h0,        0, 0,  32'h0,        0, 0,  0));
        vecs.push_back(mk(0, 1, 1, 10, 10, 0, 0, 0, 32'h0,       0, 10, 0, 32'h0,        0, 0,  32'h0,        0, 0,  1));
        vecs.push_back(mk(0, 0, 1, 10, 11, 1, 10, 10, 32'h33,    1, 10, 5, 32'h0,        1, 10, 32'h11,       0, 0,  0));
        vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0, 32'h0,        0, 10, 0, 32'h0,        1, 10, 32'h0,        0, 0,  0));
        vecs.push_back(mk(0, 1, 0, 0, 0,  1, 10, 10, 32'h33,     0, 10, 0, 32'h33,       0, 10, 32'h0,        0, 0,  0));
        vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0, 32'h0,        0, 10, 6, 32'h33,       0, 10, 32'h22,       0, 0,  0));
        vecs.push_back(mk(1, 0, 1, 12, 1, 1, 10, 10, 32'h99,     1, 10, 6, 32'h33,       0, 10, 32'h22,       0, 0,  0));
        vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0, 32'h0,        0, 10, 6, 32'h0,        0, 0,  32'h0,        0, 0,  1));
        vecs.push_back(mk(0, 1, 0, 0, 0,  0, 0, 0, 32'h0,        0, 12, 5, 32'h0,        0, 0,  32'h0,        0, 0,  1));

        foreach (vecs[i]) apply_stimulus(vecs[i], i);

        // Commit and re-rename of the same register in one cycle, then the newer producer retires.
        apply_stimulus(mk(0, 1, 1, 7, 5,  0, 0, 0, 32'h0,  0, 7, 0, 32'h0,  0, 0, 32'h0, 0, 0, 1), 100);
        apply_stimulus(mk(0, 1, 1, 7, 6,  1, 7, 5, 32'h77, 0, 7, 0, 32'h77, 0, 5, 32'h0, 0, 0, 0), 101);
        apply_stimulus(mk(0, 1, 0, 0, 0,  1, 7, 6, 32'h78, 0, 7, 7, 32'h78, 0, 6, 32'h78, 0, 6, 0), 102);
        apply_stimulus(mk(0, 1, 0, 0, 0,  0, 0, 0, 32'h0,  0, 7, 0, 32'h78, 0, 6, 32'h0, 0, 0, 0), 103);

        if (sb.size() != 0) begin
            n_checks++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries, expected 0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_register_file
